uart_irda_tx: RTL and testbench

UART_IRDA_TX -- requirements
Module: uart_irda_tx

---
 rtl/uart_irda_tx.sv | 143 ++++++++++++++
 tb/tb_uart_irda_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_irda_tx.sv
// uart_irda_tx
//   8N1 UART transmitter with a parallel IrDA SIR output. A one-cycle start
//   request in IDLE latches data_in and sends start bit, 8 data bits (LSB
//   first) and stop bit. Each bit lasts BAUD_DIV clocks.
//
// Handshake: start is a request pulse. It is accepted on any rising edge
//   where the FSM is in IDLE, including the done cycle. While busy=1, start
//   is ignored and nothing is queued. There is no ready/valid pair; busy is
//   the only back-pressure indication.
//
// Ports
//   clock     : system clock, rising edge active
//   reset     : asynchronous, active-low
//   start     : send request (one cycle, or held for repeated frames)
//   data_in   : byte to send, sampled when start is accepted
//   tx        : UART NRZ line, idle high (registered)
//   irda_tx   : IrDA LED drive, IRDA_PW-clock pulse at start of each 0 bit
//   busy      : high while a frame is in progress
//   done      : one-cycle pulse in the first IDLE cycle after a frame
//   dbg_state : current FSM state, for checkers and debug
module uart_irda_tx #(
  parameter int BAUD_DIV = 5208,
  parameter int IRDA_PW  = (3 * BAUD_DIV) / 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       irda_tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] PW       = 16'(IRDA_PW);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n, irda_n, busy_n, done_n;
  logic        wrap;

  assign dbg_state = state;
  assign wrap      = (baud_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      irda_tx  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      irda_tx  <= irda_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Outputs are computed from the next state/counter so that the registered
  // tx/irda_tx line up with the bit period they belong to (tx=0 is visible in
  // the first cycle after acceptance).
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        if (start) begin
          shreg_n = data_in;
          state_n = START;
        end
      end
      START: begin
        if (wrap) begin
          baud_cnt_n = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (wrap) begin
          baud_cnt_n = '0;
          // Shift so the next data bit is always at shreg[0].
          shreg_n    = shreg >> 1;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (wrap) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
          done_n     = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase

    // IrDA SIR: a short high pulse at the start of every zero bit only.
    irda_n = !tx_n && (baud_cnt_n < PW);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_irda_tx.sv
// Testbench for uart_irda_tx with BAUD_DIV=16, IRDA_PW=3.
// Expected line behaviour comes from a frame-level model: a frame of byte d is
// the 10-bit sequence {0, d[0..7], 1}; bit k occupies cycles 16k..16k+15 after
// acceptance, irda is high for the first 3 cycles of each 0 bit, busy is high
// for 160 cycles, then one done cycle. Each queue entry is {tx,irda,busy,done}.
module tb_uart_irda_tx;

  localparam int BD = 16;
  localparam int PW = 3;
  localparam logic [3:0] IDLE_V = 4'b1000;
  localparam logic [3:0] DONE_V = 4'b1001;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       tx, irda_tx, busy, done;
  logic [1:0] dbg_state;

  logic [3:0] exp_q[$];
  logic [3:0] got_v, exp_v;
  int n_cmp;
  int n_err;

  uart_irda_tx #(.BAUD_DIV(BD), .IRDA_PW(PW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .tx        (tx),
    .irda_tx   (irda_tx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: push the expected 161-cycle trace of one frame
  task automatic push_frame(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int c = 0; c < 10 * BD; c++) begin
      int b;
      int p;
      b = c / BD;
      p = c % BD;
      exp_q.push_back({bits[b], (bits[b] == 1'b0) && (p < PW), 1'b1, 1'b0});
    end
    exp_q.push_back(DONE_V);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(IDLE_V);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clock);
    got_v = {tx, irda_tx, busy, done};
    n_cmp++;
    if (got_v !== IDLE_V) begin
      n_err++;
      $display("FAIL reset_hold got=%b exp=%b", got_v, IDLE_V);
    end
    reset = 1'b1;
    push_idle(4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_idle c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
  endtask

  // 0xA5: tx 0,1,0,1,0,0,1,0,1,1; irda pulses in bits 0,2,4,5,7
  task automatic test_a5;
    push_frame(8'hA5);
    push_idle(3);
    start = 1'b1; data_in = 8'hA5;
    for (int c = 0; c < 164; c++) begin
      @(negedge clock);
      start = 1'b0;
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL a5 c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      int gap;
      d = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 5);
      push_idle(gap);
      for (int c = 0; c < gap; c++) begin
        @(negedge clock);
        got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
        n_cmp++;
        if (got_v !== exp_v) begin
          n_err++;
          if (n_err < 30) $display("FAIL rand_gap k=%0d c=%0d got=%b exp=%b", k, c, got_v, exp_v);
        end
      end
      push_frame(d);
      start = 1'b1; data_in = d;
      for (int c = 0; c < 161; c++) begin
        @(negedge clock);
        start = 1'b0;
        data_in = 8'($urandom_range(0, 255));
        got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
        n_cmp++;
        if (got_v !== exp_v) begin
          n_err++;
          if (n_err < 30) $display("FAIL rand d=%h c=%0d got=%b exp=%b", d, c, got_v, exp_v);
        end
      end
    end
  endtask

  // start with 0xFF mid-frame must be ignored and not queued
  task automatic test_busy_reject;
    push_frame(8'h00);
    push_idle(8);
    start = 1'b1; data_in = 8'h00;
    for (int c = 0; c < 169; c++) begin
      @(negedge clock);
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL busy_reject c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      start = (c == 50);
      if (c == 50) data_in = 8'hFF;
    end
  endtask

  // asynchronous reset at cycle 70 abandons the frame with no done pulse
  task automatic test_mid_reset;
    push_frame(8'hA5);
    start = 1'b1; data_in = 8'hA5;
    for (int c = 0; c <= 70; c++) begin
      @(negedge clock);
      start = 1'b0;
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL mid_reset_pre c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    got_v = {tx, irda_tx, busy, done};
    n_cmp++;
    if (got_v !== IDLE_V) begin
      n_err++;
      $display("FAIL mid_reset_async got=%b exp=%b", got_v, IDLE_V);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 3) reset = 1'b1;
      got_v = {tx, irda_tx, busy, done};
      n_cmp++;
      if (got_v !== IDLE_V) begin
        n_err++;
        $display("FAIL mid_reset_hold c=%0d got=%b exp=%b", c, got_v, IDLE_V);
      end
    end
    push_frame(8'h5A);
    start = 1'b1; data_in = 8'h5A;
    for (int c = 0; c < 161; c++) begin
      @(negedge clock);
      start = 1'b0;
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL mid_reset_post c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
  endtask

  // start in the done cycle: second frame begins on the next cycle
  task automatic test_back_to_back;
    push_frame(8'hC3);
    push_frame(8'h3C);
    push_idle(2);
    start = 1'b1; data_in = 8'hC3;
    for (int c = 0; c < 324; c++) begin
      @(negedge clock);
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      start = (c == 160);
      if (c == 160) data_in = 8'h3C;
    end
  endtask

  // data_in changes right after acceptance: 0x81 must still be sent
  task automatic test_data_change;
    push_frame(8'h81);
    start = 1'b1; data_in = 8'h81;
    for (int c = 0; c < 161; c++) begin
      @(negedge clock);
      start = 1'b0;
      data_in = 8'h7E;
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL data_change c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
  endtask

  // start held high: a new frame starts each time IDLE is reached
  task automatic test_held_start;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    push_frame(d);
    push_frame(d);
    push_idle(4);
    start = 1'b1; data_in = d;
    for (int c = 0; c < 326; c++) begin
      @(negedge clock);
      if (c == 321) start = 1'b0;
      got_v = {tx, irda_tx, busy, done}; exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (n_err < 30) $display("FAIL held_start c=%0d got=%b exp=%b", c, got_v, exp_v);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_a5();
    test_random();
    test_busy_reject();
    test_mid_reset();
    test_back_to_back();
    test_data_change();
    test_held_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
